// File: rtl/ibus_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : ibus_arbiter_if
// Desc     : Two-master request bus plus ibus read/write port for ibus_arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface ibus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [1:0]      m_req;
  logic [1:0]      m_we;
  logic [2*AW-1:0] m_adr;
  logic [2*DW-1:0] m_wdata;
  logic [1:0]      m_lock;
  logic [1:0]      m_ack;
  logic [1:0]      m_rvalid;
  logic [DW-1:0]   m_rdata;
  logic            ren;
  logic [AW-1:0]   ibus_radr;
  logic [DW-1:0]   ibus_rdata;
  logic            wen;
  logic [AW-1:0]   ibus_wadr;
  logic [DW-1:0]   ibus_wdata;

  // Environment side: drives the master requests and the ibus read data.
  modport master (
    output m_req, m_we, m_adr, m_wdata, m_lock, ibus_rdata,
    input  m_ack, m_rvalid, m_rdata, ren, ibus_radr, wen, ibus_wadr, ibus_wdata
  );

  // Arbiter side.
  modport slave (
    input  m_req, m_we, m_adr, m_wdata, m_lock, ibus_rdata,
    output m_ack, m_rvalid, m_rdata, ren, ibus_radr, wen, ibus_wadr, ibus_wdata
  );
endinterface

`default_nettype wire

// File: rtl/ibus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : ibus_arbiter
// Desc     : Round-robin arbiter of two masters onto a single-slot ibus with
//            read-owner tag pipeline. Optional burst lock: IBUS_ARB_LOCK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module ibus_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  ibus_arbiter_if.slave bus
);

  logic              r_last;
  logic              r_ren;
  logic              r_wen;
  logic [AW-1:0]     r_radr;
  logic [AW-1:0]     r_wadr;
  logic [DW-1:0]     r_wdata;
  logic              r_rd_owner;
  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_own;

  logic              w_grant;
  logic              w_win;
  logic              w_hold;
  logic [1:0]        w_ack;
  logic [AW-1:0]     w_sel_adr;
  logic [DW-1:0]     w_sel_wdata;
  logic              w_sel_we;

`ifdef IBUS_ARB_LOCK_EN
  logic [3:0]        r_lock_cnt;

  // Locked owner keeps a contested slot until the counter saturates.
  assign w_hold = bus.m_lock[r_last] && (r_lock_cnt != 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_cnt <= 4'd0;
    end else if (w_grant) begin
      if ((w_win == r_last) && bus.m_lock[w_win]) begin
        if (r_lock_cnt != 4'd15) begin
          r_lock_cnt <= r_lock_cnt + 4'd1;
        end
      end else begin
        r_lock_cnt <= 4'd0;
      end
    end
  end
`else
  logic w_unused_lock;

  assign w_hold        = 1'b0;
  assign w_unused_lock = ^bus.m_lock;
`endif

  always_comb begin
    w_ack   = 2'b00;
    w_win   = 1'b0;
    w_grant = rst_n && (bus.m_req != 2'b00);
    if (bus.m_req == 2'b11) begin
      w_win = w_hold ? r_last : ~r_last;
    end else begin
      w_win = bus.m_req[1];
    end
    if (w_grant) begin
      w_ack = w_win ? 2'b10 : 2'b01;
    end
  end

  assign w_sel_adr   = w_win ? bus.m_adr[AW +: AW]   : bus.m_adr[0 +: AW];
  assign w_sel_wdata = w_win ? bus.m_wdata[DW +: DW] : bus.m_wdata[0 +: DW];
  assign w_sel_we    = bus.m_we[w_win];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last     <= 1'b1;
      r_ren      <= 1'b0;
      r_wen      <= 1'b0;
      r_radr     <= '0;
      r_wadr     <= '0;
      r_wdata    <= '0;
      r_rd_owner <= 1'b0;
    end else begin
      r_ren <= w_grant && !w_sel_we;
      r_wen <= w_grant && w_sel_we;
      if (w_grant) begin
        r_last <= w_win;
        if (w_sel_we) begin
          r_wadr  <= w_sel_adr;
          r_wdata <= w_sel_wdata;
        end else begin
          r_radr     <= w_sel_adr;
          r_rd_owner <= w_win;
        end
      end
    end
  end

  // Stage 0 is loaded in the cycle after ren, so the last stage lines up
  // with ibus_rdata RD_LAT cycles after the strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_own <= '0;
    end else begin
      r_tag_vld[0] <= r_ren;
      r_tag_own[0] <= r_rd_owner;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_own[i] <= r_tag_own[i-1];
      end
    end
  end

  assign bus.m_ack      = w_ack;
  assign bus.m_rvalid   = !r_tag_vld[RD_LAT-1] ? 2'b00 :
                          (r_tag_own[RD_LAT-1] ? 2'b10 : 2'b01);
  assign bus.m_rdata    = bus.ibus_rdata;
  assign bus.ren        = r_ren;
  assign bus.ibus_radr  = r_radr;
  assign bus.wen        = r_wen;
  assign bus.ibus_wadr  = r_wadr;
  assign bus.ibus_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ibus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_ibus_arbiter
// Desc     : Directed and random stimulus for ibus_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_ibus_arbiter;
  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibus_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  ibus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic          pend [2];
  logic          we   [2];
  logic [AW-1:0] adr  [2];
  logic [DW-1:0] wd   [2];
  logic          lck  [2];
  logic [DW-1:0] drv_rdata;

  typedef struct {
    int            owner;
    logic [AW-1:0] adr;
  } rd_t;

  bit            mvalid = 1'b0;
  int            last   = 1;
  int            run    = 0;
  logic          e_ren, e_wen;
  logic [AW-1:0] e_radr, e_wadr;
  logic [DW-1:0] e_wdata;
  rd_t           sched [int];

  logic [1:0]    obs_ack;
  logic [1:0]    rv_log [int];
  logic [DW-1:0] rd_log [int];
  logic          ren_log [int];
  logic          hist_v [RD_LAT];
  logic [AW-1:0] hist_a [RD_LAT];

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      bus.m_req[i]              = pend[i];
      bus.m_we[i]               = we[i];
      bus.m_lock[i]             = lck[i];
      bus.m_adr[i*AW +: AW]     = adr[i];
      bus.m_wdata[i*DW +: DW]   = wd[i];
    end
    bus.ibus_rdata = drv_rdata;
  endtask

  // Round robin: contested slot goes to whoever was not granted last, unless
  // the last owner holds lock and its run of grants is still below 16.
  function automatic logic [1:0] model_ack();
    int w;
    if (!rst_n || (!pend[0] && !pend[1])) return 2'b00;
    if (pend[0] && pend[1]) begin
      w = 1 - last;
`ifdef IBUS_ARB_LOCK_EN
      if (lck[last] && run < 16) w = last;
`endif
    end else begin
      w = pend[1] ? 1 : 0;
    end
    return (w == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    logic [1:0] ea;
    int         w;
    @(negedge clk);
    ea = model_ack();
    chk("m_ack", 32'(bus.m_ack), 32'(ea));
    obs_ack      = bus.m_ack;
    rv_log[cyc]  = bus.m_rvalid;
    rd_log[cyc]  = bus.m_rdata;
    ren_log[cyc] = bus.ren;
    if (mvalid) begin
      chk("ren",        32'(bus.ren),        32'(e_ren));
      chk("wen",        32'(bus.wen),        32'(e_wen));
      chk("ibus_radr",  32'(bus.ibus_radr),  32'(e_radr));
      chk("ibus_wadr",  32'(bus.ibus_wadr),  32'(e_wadr));
      chk("ibus_wdata", 32'(bus.ibus_wdata), 32'(e_wdata));
      if (sched.exists(cyc)) begin
        chk("m_rvalid", 32'(bus.m_rvalid), (sched[cyc].owner == 1) ? 32'd2 : 32'd1);
        chk("rd_data",  32'(bus.m_rdata),  32'(mem_val(sched[cyc].adr)));
        sched.delete(cyc);
      end else begin
        chk("m_rvalid", 32'(bus.m_rvalid), 32'd0);
      end
      chk("m_rdata_pass", 32'(bus.m_rdata), 32'(drv_rdata));
    end
    for (int k = RD_LAT - 1; k > 0; k--) begin
      hist_v[k] = hist_v[k-1];
      hist_a[k] = hist_a[k-1];
    end
    hist_v[0] = (bus.ren === 1'b1);
    hist_a[0] = bus.ibus_radr;
    if (!rst_n) begin
      e_ren   = 1'b0;  e_wen  = 1'b0;
      e_radr  = '0;    e_wadr = '0;   e_wdata = '0;
      last    = 1;     run    = 0;
      for (int k = 1; k <= RD_LAT + 1; k++) sched.delete(cyc + k);
      mvalid  = 1'b1;
    end else begin
      e_ren = 1'b0;
      e_wen = 1'b0;
      if (ea != 2'b00) begin
        w = ea[1] ? 1 : 0;
        if (we[w]) begin
          e_wen = 1'b1; e_wadr = adr[w]; e_wdata = wd[w];
        end else begin
          e_ren = 1'b1; e_radr = adr[w];
          sched[cyc + 1 + RD_LAT] = '{owner: w, adr: adr[w]};
        end
        if (w != last || !lck[w]) run = 1;
        else run++;
        last    = w;
        pend[w] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    drv_rdata = hist_v[RD_LAT-1] ? mem_val(hist_a[RD_LAT-1]) : DW'($urandom);
    drive();
  endtask

  task automatic set_m(input int i, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic l);
    pend[i] = 1'b1; we[i] = w; adr[i] = a; wd[i] = d; lck[i] = l;
  endtask

  task automatic do_reset();
    pend[0] = 1'b0; pend[1] = 1'b0;
    rst_n = 1'b0; drive();
    tick(); tick();
    rst_n = 1'b1; drive();
  endtask

  task automatic rand_masters();
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 3) != 0)
        set_m(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
              1'($urandom_range(0, 1)));
    end
    rst_n = ($urandom_range(0, 199) != 0);
    drive();
  endtask

  initial begin
    int         t0;
    logic [1:0] acks [4];
    logic [1:0] exp4 [4];
    exp4 = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wd[i] = '0; lck[i] = 1'b0;
    end
    for (int k = 0; k < RD_LAT; k++) begin
      hist_v[k] = 1'b0; hist_a[k] = '0;
    end
    drv_rdata = '0;
    drive();
    @(posedge clk);
    #1;

    // Single write from master 0
    do_reset();
    chk("rst_ren", 32'(bus.ren), 32'd0);
    chk("rst_wadr", 32'(bus.ibus_wadr), 32'd0);
    set_m(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0); drive();
    tick();
    chk("wr_ack",   32'(obs_ack),        32'd1);
    chk("wr_wen",   32'(bus.wen),        32'd1);
    chk("wr_wadr",  32'(bus.ibus_wadr),  32'h0010);
    chk("wr_wdata", 32'(bus.ibus_wdata), 32'hBEEF);
    tick();
    chk("wr_wen_off", 32'(bus.wen), 32'd0);

    // Both masters reading continuously
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i]) set_m(i, 1'b0, AW'($urandom), '0, 1'b0);
      drive();
      tick();
      acks[k] = obs_ack;
    end
    pend[0] = 1'b0; pend[1] = 1'b0; drive();
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_ack%0d", k), 32'(acks[k]), 32'(exp4[k]));
      chk($sformatf("rr_rv%0d", k), 32'(rv_log[t0 + 2 + k]), 32'(exp4[k]));
    end

    // m1 read then m0 read, back to back
    do_reset();
    t0 = cyc;
    set_m(1, 1'b0, 16'h0100, '0, 1'b0); drive(); tick();
    set_m(0, 1'b0, 16'h0200, '0, 1'b0); drive(); tick();
    tick(); tick();
    chk("b2b_ren0", 32'(ren_log[t0 + 1]), 32'd1);
    chk("b2b_ren1", 32'(ren_log[t0 + 2]), 32'd1);
    chk("b2b_rv0",  32'(rv_log[t0 + 2]),  32'd2);
    chk("b2b_rd0",  32'(rd_log[t0 + 2]),  32'(mem_val(16'h0100)));
    chk("b2b_rv1",  32'(rv_log[t0 + 3]),  32'd1);
    chk("b2b_rd1",  32'(rd_log[t0 + 3]),  32'(mem_val(16'h0200)));

    // Reset right after a read acceptance drops the read
    do_reset();
    t0 = cyc;
    set_m(0, 1'b0, 16'h0300, '0, 1'b0); drive(); tick();
    rst_n = 1'b0; drive(); tick();
    rst_n = 1'b1; drive(); tick(); tick();
    chk("rstrd_rv2", 32'(rv_log[t0 + 2]), 32'd0);
    chk("rstrd_rv3", 32'(rv_log[t0 + 3]), 32'd0);
    set_m(0, 1'b0, 16'h0400, '0, 1'b0);
    set_m(1, 1'b0, 16'h0500, '0, 1'b0);
    drive(); tick();
    chk("rstrd_first", 32'(obs_ack), 32'd1);
    pend[1] = 1'b0; drive(); tick();

    // Master 0 with lock against master 1
    do_reset();
    for (int k = 0; k < 17; k++) begin
      if (!pend[0]) set_m(0, 1'b0, AW'($urandom), '0, 1'b1);
      if (!pend[1]) set_m(1, 1'b0, AW'($urandom), '0, 1'b0);
      drive();
      tick();
`ifdef IBUS_ARB_LOCK_EN
      chk($sformatf("lock_ack%0d", k), 32'(obs_ack), (k < 16) ? 32'd1 : 32'd2);
`else
      chk($sformatf("lock_ack%0d", k), 32'(obs_ack), (k % 2 == 0) ? 32'd1 : 32'd2);
`endif
    end

    // Random traffic with occasional reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_masters();
      tick();
    end
    rst_n = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0; drive();
    for (int n = 0; n < RD_LAT + 3; n++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
